// File: rtl/fifo_arb_pkg.sv
// Shared types and constants for the FIFO write-port arbiter.
// Optional stall counter: FIFO_ARB_STALL_CNT_EN.
package fifo_arb_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    XFER = 1'b1
  } arb_state_t;

  localparam int STALL_CNT_W = 16;

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester with req high,
// searching from last_owner+1 upward and wrapping modulo N.
module rr_pick #(
  parameter int N = 4,
  localparam int OW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [OW-1:0] last_owner,
  output logic [OW-1:0] winner,
  output logic          valid
);

  localparam logic [OW:0] N_EXT = (OW+1)'(N);

  logic [OW:0]   sum  [N];
  logic [OW-1:0] cand [N];

  // cand[gi] is the requester index at rotation distance gi+1 from last_owner
  for (genvar gi = 0; gi < N; gi++) begin : g_cand
    assign sum[gi]  = {1'b0, last_owner} + (OW+1)'(gi + 1);
    assign cand[gi] = (sum[gi] >= N_EXT) ? OW'(sum[gi] - N_EXT) : sum[gi][OW-1:0];
  end

  // Scan farthest to nearest so the nearest requesting candidate wins.
  always_comb begin
    winner = '0;
    valid  = 1'b0;
    for (int k = N - 1; k >= 0; k--) begin
      if (req[cand[k]]) begin
        winner = cand[k];
        valid  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin, burst-locked arbiter for a single FIFO write port.
// Optional stall counter port enabled by FIFO_ARB_STALL_CNT_EN.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int N         = 4,
  parameter int MAX_BURST = 16,
  localparam int OW = $clog2(N)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N-1:0]       req,
  input  logic [N*WIDTH-1:0] wdata_in,
  input  logic [N-1:0]       last,
  output logic [N-1:0]       gnt,
  input  logic               fifo_full,
  output logic               fifo_wr_en,
  output logic [WIDTH-1:0]   fifo_wdata,
  output logic               busy,
  output logic [OW-1:0]      owner
`ifdef FIFO_ARB_STALL_CNT_EN
  ,
  output logic [STALL_CNT_W-1:0] stall_cnt
`endif
);

  localparam int BW = $clog2(MAX_BURST + 1);

  arb_state_t    state_reg, state_next;
  logic [OW-1:0] owner_reg, owner_next;
  logic [OW-1:0] last_owner_reg, last_owner_next;
  logic [BW-1:0] beat_cnt_reg, beat_cnt_next;

  logic [WIDTH-1:0] word [N];
  logic [OW-1:0]    pick_idx;
  logic             pick_valid;
  logic             req_own;
  logic             last_own;
  logic             accept;

  for (genvar gi = 0; gi < N; gi++) begin : g_unpack
    assign word[gi] = wdata_in[gi*WIDTH +: WIDTH];
  end

  rr_pick #(.N(N)) u_pick (
    .req        (req),
    .last_owner (last_owner_reg),
    .winner     (pick_idx),
    .valid      (pick_valid)
  );

  // Full is honoured in the same cycle, so the FIFO never sees a write while full.
  assign req_own  = req[owner_reg];
  assign last_own = last[owner_reg];
  assign accept   = (state_reg == XFER) && req_own && !fifo_full;

  for (genvar gi = 0; gi < N; gi++) begin : g_gnt
    assign gnt[gi] = accept && (owner_reg == OW'(gi));
  end

  assign fifo_wr_en = accept;
  assign fifo_wdata = accept ? word[owner_reg] : '0;
  assign busy       = (state_reg == XFER);
  assign owner      = owner_reg;

  always_comb begin
    state_next      = state_reg;
    owner_next      = owner_reg;
    last_owner_next = last_owner_reg;
    beat_cnt_next   = beat_cnt_reg;
    case (state_reg)
      IDLE: begin
        if (pick_valid) begin
          owner_next    = pick_idx;
          beat_cnt_next = '0;
          state_next    = XFER;
        end
      end
      XFER: begin
        if (!req_own) begin
          state_next      = IDLE;
          last_owner_next = owner_reg;
        end else if (accept) begin
          beat_cnt_next = beat_cnt_reg + 1'b1;
          if (last_own || (beat_cnt_reg == BW'(MAX_BURST - 1))) begin
            state_next      = IDLE;
            last_owner_next = owner_reg;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      owner_reg      <= '0;
      last_owner_reg <= OW'(N - 1);
      beat_cnt_reg   <= '0;
    end else begin
      state_reg      <= state_next;
      owner_reg      <= owner_next;
      last_owner_reg <= last_owner_next;
      beat_cnt_reg   <= beat_cnt_next;
    end
  end

`ifdef FIFO_ARB_STALL_CNT_EN
  logic [STALL_CNT_W-1:0] stall_cnt_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_reg <= '0;
    end else if ((state_reg == XFER) && req_own && fifo_full && (stall_cnt_reg != '1)) begin
      stall_cnt_reg <= stall_cnt_reg + 1'b1;
    end
  end

  assign stall_cnt = stall_cnt_reg;
`endif

endmodule
